tile_scheduler: RTL and testbench
=================================

// Module: tile_scheduler
// PURPOSE
//  Sequences the tile pipeline feeding the framebuffer. Hands free tile buffers (A=0, B=1) to the
//  tile renderer in raster order, triggers the framebuffer to stream each filled buffer at its
//  screen offset, and swaps doubleBuffer on the vsync after a frame's last tile is written.
// PARAMETERS
//  tileDim  8    tile edge, pixels
//  screenW  640  drawn width, pixels (multiple of tileDim)
//  screenH  480  drawn height, pixels (multiple of tileDim)
// PORTS
//  BOARD_CLK          in   1   50 MHz system clock
//  RESET              in   1   asynchronous, active-high reset
//  VGA_VS             in   1   vsync, active low
//  renderStart        out  1   1-cycle pulse: render tile (renderX,renderY) into buffer renderTileID
//  renderX, renderY   out  10  pixel offset of tile to render
//  renderTileID       out  1   destination buffer
//  renderDone         in   1   1-cycle pulse: buffer renderTileID filled
//  streamTileTrigger  out  1   to framebuffer, held 2 cycles
//  xOffset, yOffset   out  10  offset of tile being streamed
//  nextStreamingTileID out 1   buffer being streamed (valid from trigger)
//  streamingTileID    out  1   nextStreamingTileID delayed 1 cycle
//  doneStreaming      in   1   from framebuffer; high while idle
//  doubleBuffer       out  1   framebuffer write/read page select
//  frameDone          out  1   1-cycle pulse at buffer swap
// BEHAVIOUR
//  Reset: all outputs 0; both buffers free; render/stream pointers (0,0); stream FSM S_WAIT_FULL.
//  Buffer status: full[1:0]. renderDone sets full[renderTileID]; stream completion clears it. Same-
//   cycle set/clear on different buffers both apply; same buffer cannot occur (renderer owns it).
//  Render FSM R_IDLE->R_BUSY: in R_IDLE, if buffer renderTileID not full and render pointer not
//   parked, pulse renderStart, go R_BUSY. On renderDone: advance pointer, toggle renderTileID, R_IDLE.
//   After the frame's last tile, render pointer parks until frameDone, then wraps to (0,0).
//  Stream FSM:
//   S_WAIT_FULL: full[streamID] && doneStreaming -> S_TRIGGER; latch xOffset/yOffset from stream ptr.
//   S_TRIGGER: streamTileTrigger=1 for exactly 2 cycles (framebuffer alternates VGA/stream slots)
//    -> S_WAIT_BUSY.
//   S_WAIT_BUSY: doneStreaming==0 -> S_WAIT_DONE.
//   S_WAIT_DONE: doneStreaming==1 -> clear full[streamID], toggle streamID, advance pointer;
//    if tile was last of frame -> S_WAIT_VS else S_WAIT_FULL.
//   S_WAIT_VS: on VGA_VS falling edge (registered prev value) toggle doubleBuffer, pulse frameDone,
//    wrap stream ptr, -> S_WAIT_FULL. Vsync edges in other states ignored (frame late: swap deferred).
//  Pointer advance: x += tileDim; at x==screenW-tileDim, x=0, y += tileDim; last tile is
//   (screenW-tileDim, screenH-tileDim). All arithmetic 10-bit unsigned, no overflow for legal params.
//  Latency: renderDone -> trigger asserted 1 cycle later if framebuffer idle.
//  Reset mid-operation: state discarded; first trigger still waits doneStreaming==1, so an
//   in-flight framebuffer stream finishes unharmed; partially rendered buffer is re-rendered.
// CONFIGURATION
//  TILE_SCHED_PERF_EN defined: adds outputs frameCount[15:0] (increments at frameDone, wraps) and
//   stallCycles[15:0] (cycles in S_WAIT_FULL with doneStreaming=1 and full[streamID]=0; saturates
//   at 16'hFFFF; cleared at frameDone). Undefined: ports and counters absent, behaviour unchanged.
// STRUCTURE
//  typhoon_pkg: stream_state_t enum, render_state_t enum, tile_id_t, TILE_A=0/TILE_B=1 constants.
//  Sub-module tile_raster_counter (tileDim, screenW, screenH): advance/wrap inputs, x/y/last outputs;
//   instantiated twice (render pointer, stream pointer).
// TESTING (screenW=32, screenH=16, tileDim=8: 8 tiles/frame)
//  1 Reset, renderer model replies renderDone 5 cycles after start -> renderStart (0,0,ID0) then
//    (8,0,ID1); trigger offsets (0,0) then (8,0), each trigger exactly 2 cycles high.
//  2 Hold doneStreaming=1 never dropping after trigger -> FSM stays S_WAIT_BUSY, no 2nd trigger.
//  3 Stream all 8 tiles, VS falls -> doubleBuffer 0->1, frameDone 1 cycle, next render (0,0);
//    no render of 9th tile before frameDone.
//  4 renderDone(ID1) same cycle as stream completion of ID0 -> full goes 01->10, no lost update.
//  5 VS falls while 6th tile streaming -> no swap; swap on next VS after 8th tile.
//  6 RESET asserted during S_WAIT_DONE with doneStreaming=0 -> outputs 0 next edge; after release
//    no trigger until doneStreaming=1; PERF_EN build: frameCount=0, stallCycles counts idle gaps.

Source files
------------

// File: rtl/typhoon_pkg.sv
// Shared types for the tile pipeline: buffer IDs, FSM state encodings and coordinate width.
package typhoon_pkg;

    typedef logic tile_id_t;

    localparam tile_id_t TILE_A = 1'b0;
    localparam tile_id_t TILE_B = 1'b1;

    localparam int unsigned CoordW = 10;

    typedef enum logic [2:0] {
        StWaitFull,
        StTrigger,
        StWaitBusy,
        StWaitDone,
        StWaitVs
    } stream_state_t;

    typedef enum logic {
        RndIdle,
        RndBusy
    } render_state_t;

endpackage

// File: rtl/tile_raster_counter.sv
// Raster-order tile pointer: steps x by tileDim, wraps into the next row, flags the frame's last
// tile. Advancing past the last tile returns to (0,0); wrap forces (0,0).
module tile_raster_counter
    import typhoon_pkg::*;
#(
    parameter int unsigned tileDim = 8,
    parameter int unsigned screenW = 640,
    parameter int unsigned screenH = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              wrap,
    output logic [CoordW-1:0] x,
    output logic [CoordW-1:0] y,
    output logic              last
);

    localparam logic [CoordW-1:0] Step  = CoordW'(tileDim);
    localparam logic [CoordW-1:0] LastX = CoordW'(screenW - tileDim);
    localparam logic [CoordW-1:0] LastY = CoordW'(screenH - tileDim);

    logic [CoordW-1:0] xPos_q, xPos_d;
    logic [CoordW-1:0] yPos_q, yPos_d;

    assign last = (xPos_q == LastX) && (yPos_q == LastY);
    assign x    = xPos_q;
    assign y    = yPos_q;

    always_comb begin
        xPos_d = xPos_q;
        yPos_d = yPos_q;
        if (wrap) begin
            xPos_d = '0;
            yPos_d = '0;
        end else if (advance) begin
            if (xPos_q == LastX) begin
                xPos_d = '0;
                yPos_d = last ? '0 : yPos_q + Step;
            end else begin
                xPos_d = xPos_q + Step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xPos_q <= '0;
            yPos_q <= '0;
        end else begin
            xPos_q <= xPos_d;
            yPos_q <= yPos_d;
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// Double-buffered tile sequencer between renderer and framebuffer, with vsync page swap.
// Define TILE_SCHED_PERF_EN to add the frameCount/stallCycles performance counters.
module tile_scheduler
    import typhoon_pkg::*;
#(
    parameter int unsigned tileDim = 8,
    parameter int unsigned screenW = 640,
    parameter int unsigned screenH = 480
) (
    input  logic              BOARD_CLK,
    input  logic              RESET,
    input  logic              VGA_VS,
    output logic              renderStart,
    output logic [CoordW-1:0] renderX,
    output logic [CoordW-1:0] renderY,
    output tile_id_t          renderTileID,
    input  logic              renderDone,
    output logic              streamTileTrigger,
    output logic [CoordW-1:0] xOffset,
    output logic [CoordW-1:0] yOffset,
    output tile_id_t          nextStreamingTileID,
    output tile_id_t          streamingTileID,
    input  logic              doneStreaming,
    output logic              doubleBuffer,
`ifdef TILE_SCHED_PERF_EN
    output logic [15:0]       frameCount,
    output logic [15:0]       stallCycles,
`endif
    output logic              frameDone
);

    render_state_t     renderState_q, renderState_d;
    stream_state_t     streamState_q, streamState_d;
    tile_id_t          renderId_q, renderId_d;
    tile_id_t          streamId_q, streamId_d;
    tile_id_t          nextId_q, nextId_d;
    tile_id_t          curId_q;
    logic [1:0]        full_q, full_d, fullSet, fullClr, fullNow;
    logic              parked_q, parked_d;
    logic              trigCnt_q, trigCnt_d;
    logic [CoordW-1:0] xOff_q, xOff_d, yOff_q, yOff_d;
    logic              dbuf_q, frameDone_q, prevVs_q;
    logic              renderAdvance, streamAdvance, swap, vsFall;
    logic [CoordW-1:0] streamX, streamY;
    logic              renderLast, streamLast;

    tile_raster_counter #(
        .tileDim (tileDim),
        .screenW (screenW),
        .screenH (screenH)
    ) u_renderPtr (
        .clk     (BOARD_CLK),
        .rst     (RESET),
        .advance (renderAdvance),
        .wrap    (swap),
        .x       (renderX),
        .y       (renderY),
        .last    (renderLast)
    );

    tile_raster_counter #(
        .tileDim (tileDim),
        .screenW (screenW),
        .screenH (screenH)
    ) u_streamPtr (
        .clk     (BOARD_CLK),
        .rst     (RESET),
        .advance (streamAdvance),
        .wrap    (swap),
        .x       (streamX),
        .y       (streamY),
        .last    (streamLast)
    );

    assign vsFall = prevVs_q && !VGA_VS;

    always_comb begin
        renderState_d = renderState_q;
        renderId_d    = renderId_q;
        parked_d      = parked_q;
        renderStart   = 1'b0;
        renderAdvance = 1'b0;
        fullSet       = '0;
        unique case (renderState_q)
            RndIdle: begin
                // Gated by RESET so the pulse cannot appear while reset is held.
                if (!full_q[renderId_q] && !parked_q && !RESET) begin
                    renderStart   = 1'b1;
                    renderState_d = RndBusy;
                end
            end
            RndBusy: begin
                if (renderDone) begin
                    fullSet[renderId_q] = 1'b1;
                    renderAdvance       = 1'b1;
                    renderId_d          = (renderId_q == TILE_A) ? TILE_B : TILE_A;
                    renderState_d       = RndIdle;
                    if (renderLast) begin
                        parked_d = 1'b1;
                    end
                end
            end
            default: renderState_d = RndIdle;
        endcase
        if (swap) begin
            parked_d = 1'b0;
        end
    end

    // Same-cycle renderDone is forwarded so the trigger follows one cycle after it.
    assign fullNow = full_q | fullSet;

    always_comb begin
        streamState_d     = streamState_q;
        trigCnt_d         = trigCnt_q;
        streamId_d        = streamId_q;
        nextId_d          = nextId_q;
        xOff_d            = xOff_q;
        yOff_d            = yOff_q;
        fullClr           = '0;
        streamAdvance     = 1'b0;
        swap              = 1'b0;
        streamTileTrigger = 1'b0;
        unique case (streamState_q)
            StWaitFull: begin
                if (fullNow[streamId_q] && doneStreaming) begin
                    xOff_d        = streamX;
                    yOff_d        = streamY;
                    nextId_d      = streamId_q;
                    trigCnt_d     = 1'b0;
                    streamState_d = StTrigger;
                end
            end
            StTrigger: begin
                streamTileTrigger = 1'b1;
                trigCnt_d         = 1'b1;
                if (trigCnt_q) begin
                    streamState_d = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (!doneStreaming) begin
                    streamState_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (doneStreaming) begin
                    fullClr[streamId_q] = 1'b1;
                    streamId_d          = (streamId_q == TILE_A) ? TILE_B : TILE_A;
                    streamAdvance       = 1'b1;
                    streamState_d       = streamLast ? StWaitVs : StWaitFull;
                end
            end
            StWaitVs: begin
                if (vsFall) begin
                    swap          = 1'b1;
                    streamState_d = StWaitFull;
                end
            end
            default: streamState_d = StWaitFull;
        endcase
    end

    assign full_d = (full_q | fullSet) & ~fullClr;

    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) begin
            renderState_q <= RndIdle;
            streamState_q <= StWaitFull;
            renderId_q    <= TILE_A;
            streamId_q    <= TILE_A;
            nextId_q      <= TILE_A;
            curId_q       <= TILE_A;
            full_q        <= '0;
            parked_q      <= 1'b0;
            trigCnt_q     <= 1'b0;
            xOff_q        <= '0;
            yOff_q        <= '0;
            dbuf_q        <= 1'b0;
            frameDone_q   <= 1'b0;
            prevVs_q      <= 1'b0;
        end else begin
            renderState_q <= renderState_d;
            streamState_q <= streamState_d;
            renderId_q    <= renderId_d;
            streamId_q    <= streamId_d;
            nextId_q      <= nextId_d;
            curId_q       <= nextId_q;
            full_q        <= full_d;
            parked_q      <= parked_d;
            trigCnt_q     <= trigCnt_d;
            xOff_q        <= xOff_d;
            yOff_q        <= yOff_d;
            frameDone_q   <= swap;
            prevVs_q      <= VGA_VS;
            if (swap) begin
                dbuf_q <= ~dbuf_q;
            end
        end
    end

    assign renderTileID        = renderId_q;
    assign xOffset             = xOff_q;
    assign yOffset             = yOff_q;
    assign nextStreamingTileID = nextId_q;
    assign streamingTileID     = curId_q;
    assign doubleBuffer        = dbuf_q;
    assign frameDone           = frameDone_q;

`ifdef TILE_SCHED_PERF_EN
    logic        stall;
    logic [15:0] frameCount_q, stallCycles_q;

    assign stall = (streamState_q == StWaitFull) && doneStreaming && !full_q[streamId_q];

    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) begin
            frameCount_q  <= '0;
            stallCycles_q <= '0;
        end else if (swap) begin
            frameCount_q  <= frameCount_q + 16'd1;
            stallCycles_q <= '0;
        end else if (stall && (stallCycles_q != 16'hFFFF)) begin
            stallCycles_q <= stallCycles_q + 16'd1;
        end
    end

    assign frameCount  = frameCount_q;
    assign stallCycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler on a 32x16 screen of 8x8 tiles (8 tiles per frame).
module tb_tile_scheduler;

    logic       BOARD_CLK = 1'b0;
    logic       RESET, VGA_VS, renderDone, doneStreaming;
    logic       renderStart, renderTileID, streamTileTrigger;
    logic       nextStreamingTileID, streamingTileID, doubleBuffer, frameDone;
    logic [9:0] renderX, renderY, xOffset, yOffset;
`ifdef TILE_SCHED_PERF_EN
    logic [15:0] frameCount, stallCycles;
`endif

    tile_scheduler #(
        .tileDim (8),
        .screenW (32),
        .screenH (16)
    ) dut (
        .BOARD_CLK           (BOARD_CLK),
        .RESET               (RESET),
        .VGA_VS              (VGA_VS),
        .renderStart         (renderStart),
        .renderX             (renderX),
        .renderY             (renderY),
        .renderTileID        (renderTileID),
        .renderDone          (renderDone),
        .streamTileTrigger   (streamTileTrigger),
        .xOffset             (xOffset),
        .yOffset             (yOffset),
        .nextStreamingTileID (nextStreamingTileID),
        .streamingTileID     (streamingTileID),
        .doneStreaming       (doneStreaming),
        .doubleBuffer        (doubleBuffer),
`ifdef TILE_SCHED_PERF_EN
        .frameCount          (frameCount),
        .stallCycles         (stallCycles),
`endif
        .frameDone           (frameDone)
    );

    always #5 BOARD_CLK = ~BOARD_CLK;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        rd;
        logic        ds;
        logic        vs;
        logic [46:0] exp;
    } vec_t;

    vec_t tbl[16];

    // Bench-side renderer / framebuffer models and event logs
    bit          enRend, enFb, prevTrig;
    int          rendWait, fbBusy, rendCnt, trigCnt, trigHigh, fdCnt;
    logic        vsLevel;
    logic [20:0] rendLog[$];
    logic [20:0] trigLog[$];

    function automatic logic [46:0] pk(input logic rs, input logic [9:0] rx, input logic [9:0] ry,
                                       input logic rid, input logic trg, input logic [9:0] xo,
                                       input logic [9:0] yo, input logic nid, input logic sid,
                                       input logic db, input logic fd);
        return {rs, rx, ry, rid, trg, xo, yo, nid, sid, db, fd};
    endfunction

    function automatic logic [46:0] obs();
        return pk(renderStart, renderX, renderY, renderTileID, streamTileTrigger, xOffset, yOffset,
                  nextStreamingTileID, streamingTileID, doubleBuffer, frameDone);
    endfunction

    function automatic logic [20:0] tileExp(input int k);
        logic [9:0] tx, ty;
        logic       tid;
        tx = 10'((k % 4) * 8);
        ty = 10'((k / 4) * 8);
        tid = 1'(k % 2);
        return {tx, ty, tid};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic rd, input logic ds, input logic [46:0] e);
        tbl[i].rd  = rd;
        tbl[i].ds  = ds;
        tbl[i].vs  = 1'b1;
        tbl[i].exp = e;
    endtask

    // One clock: sample outputs mid-cycle, then drive the next cycle's inputs after the edge.
    task automatic tick();
        @(negedge BOARD_CLK);
        if (renderStart) begin
            rendLog.push_back({renderX, renderY, renderTileID});
            rendCnt++;
            if (enRend) rendWait = 5;
        end
        if (streamTileTrigger) begin
            trigHigh++;
            if (!prevTrig) begin
                trigLog.push_back({xOffset, yOffset, nextStreamingTileID});
                trigCnt++;
            end
        end else if (prevTrig && enFb) begin
            fbBusy = 4;
        end
        prevTrig = streamTileTrigger;
        if (frameDone) fdCnt++;
        @(posedge BOARD_CLK);
        #1;
        renderDone = 1'b0;
        if (rendWait > 0) begin
            rendWait--;
            renderDone = (rendWait == 0);
        end
        if (enFb) begin
            doneStreaming = (fbBusy == 0);
            if (fbBusy > 0) fbBusy--;
        end
        VGA_VS = vsLevel;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        enRend = 0; enFb = 0; prevTrig = 0;
        rendWait = 0; fbBusy = 0; rendCnt = 0; trigCnt = 0; trigHigh = 0; fdCnt = 0;
        rendLog.delete();
        trigLog.delete();
        renderDone = 1'b0; doneStreaming = 1'b1; vsLevel = 1'b1; VGA_VS = 1'b1;
        @(negedge BOARD_CLK);
        check("reset_outputs", 64'(obs()), 64'd0);
        @(posedge BOARD_CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        setv(0,  0, 1, pk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(1,  0, 1, pk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(2,  0, 1, pk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(3,  0, 1, pk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(4,  0, 1, pk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(5,  1, 1, pk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(6,  0, 1, pk(1, 8,  0, 1, 1, 0, 0, 0, 0, 0, 0));
        setv(7,  0, 1, pk(0, 8,  0, 1, 1, 0, 0, 0, 0, 0, 0));
        setv(8,  0, 0, pk(0, 8,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        setv(9,  0, 0, pk(0, 8,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        setv(10, 0, 0, pk(0, 8,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        setv(11, 1, 1, pk(0, 8,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        setv(12, 0, 1, pk(1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(13, 0, 1, pk(0, 16, 0, 0, 1, 8, 0, 1, 0, 0, 0));
        setv(14, 0, 1, pk(0, 16, 0, 0, 1, 8, 0, 1, 1, 0, 0));
        setv(15, 0, 0, pk(0, 16, 0, 0, 0, 8, 0, 1, 1, 0, 0));

        // First two tiles cycle by cycle; cycle 11 has renderDone(ID1) with completion of ID0.
        doReset();
        for (int i = 0; i < 16; i++) begin
            renderDone    = tbl[i].rd;
            doneStreaming = tbl[i].ds;
            VGA_VS        = tbl[i].vs;
            @(negedge BOARD_CLK);
            check($sformatf("cycle%0d", i), 64'(obs()), 64'(tbl[i].exp));
            @(posedge BOARD_CLK);
            #1;
        end

        // doneStreaming never drops: one 2-cycle trigger, FSM parked in its busy wait.
        doReset();
        enRend = 1;
        repeat (40) tick();
        check("hold_trig_count", 64'(trigCnt), 64'd1);
        check("hold_trig_width", 64'(trigHigh), 64'd2);
        check("hold_render_count", 64'(rendCnt), 64'd2);
        check("hold_trig0", 64'(trigLog.size() > 0 ? trigLog[0] : 21'h1FFFFF), 64'(tileExp(0)));
        check("hold_render1", 64'(rendLog.size() > 1 ? rendLog[1] : 21'h1FFFFF), 64'(tileExp(1)));
`ifdef TILE_SCHED_PERF_EN
        check("hold_stall_cycles", 64'(stallCycles), 64'd6);
        check("hold_frame_count", 64'(frameCount), 64'd0);
`endif

        // Full frame; an early vsync during tile 6 must not swap.
        doReset();
        enRend = 1;
        enFb = 1;
        for (int i = 0; i < 600 && trigCnt < 6; i++) tick();
        check("frame_reach_tile6", 64'(trigCnt), 64'd6);
        vsLevel = 1'b0;
        repeat (3) tick();
        vsLevel = 1'b1;
        for (int i = 0; i < 600 && trigCnt < 8; i++) tick();
        repeat (30) tick();
        check("early_vs_no_swap", 64'(doubleBuffer), 64'd0);
        check("early_vs_no_framedone", 64'(fdCnt), 64'd0);
        check("parked_render_count", 64'(rendCnt), 64'd8);
        check("frame_trig_count", 64'(trigCnt), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("render_tile%0d", k),
                  64'(rendLog.size() > k ? rendLog[k] : 21'h1FFFFF), 64'(tileExp(k)));
            check($sformatf("stream_tile%0d", k),
                  64'(trigLog.size() > k ? trigLog[k] : 21'h1FFFFF), 64'(tileExp(k)));
        end
        vsLevel = 1'b0;
        for (int i = 0; i < 10 && fdCnt == 0; i++) tick();
        check("swap_double_buffer", 64'(doubleBuffer), 64'd1);
        check("swap_render_start_count", 64'(rendCnt), 64'd9);
        repeat (3) tick();
        vsLevel = 1'b1;
        check("frame_done_width", 64'(fdCnt), 64'd1);
        check("next_frame_render", 64'(rendLog.size() > 8 ? rendLog[8] : 21'h1FFFFF),
              64'(tileExp(0)));
`ifdef TILE_SCHED_PERF_EN
        check("frame_count_one", 64'(frameCount), 64'd1);
`endif

        // Reset while a stream is in flight; next trigger waits for the framebuffer to go idle.
        doReset();
        enRend = 1;
        for (int i = 0; i < 50 && trigCnt < 1; i++) tick();
        doneStreaming = 1'b0;
        repeat (6) tick();
        RESET = 1'b1;
        rendWait = 0;
        renderDone = 1'b0;
        @(negedge BOARD_CLK);
        check("midreset_outputs", 64'(obs()), 64'd0);
        @(posedge BOARD_CLK);
        #1;
        RESET = 1'b0;
        prevTrig = 0;
        trigCnt = 0;
        trigLog.delete();
        repeat (15) tick();
        check("midreset_no_trigger", 64'(trigCnt), 64'd0);
        doneStreaming = 1'b1;
        for (int i = 0; i < 10 && trigCnt < 1; i++) tick();
        check("midreset_trigger", 64'(trigCnt), 64'd1);
        check("midreset_trig_tile", 64'(trigLog.size() > 0 ? trigLog[0] : 21'h1FFFFF),
              64'(tileExp(0)));
`ifdef TILE_SCHED_PERF_EN
        check("midreset_frame_count", 64'(frameCount), 64'd0);
        check("midreset_stall_cycles", 64'(stallCycles), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
